// File: rtl/wb_sram_pkg.sv
// Shared definitions for the Wishbone-to-16-bit asynchronous SRAM bridge.
// Holds the FSM encoding, the WAIT limit and the Wishbone byte-lane groupings.
package wb_sram_pkg;

    localparam int WAIT_MAX = 15;

    // Big-endian lanes: sel[3] is the lowest byte address.
    localparam logic [3:0] SEL_HI = 4'b1100;
    localparam logic [3:0] SEL_LO = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_ACK    = 3'd4
    } state_t;

    typedef enum logic {
        HALF_HI = 1'b0,
        HALF_LO = 1'b1
    } half_t;

endpackage

// File: rtl/wb_sram.sv
// Wishbone slave bridging 32-bit longword accesses onto a 16-bit asynchronous SRAM,
// splitting each access into HI and LO halfword cycles (SETUP / STROBE x WAIT / HOLD).
module wb_sram
    import wb_sram_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [29:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic [ADDR_W-1:0] sram_a,
    input  logic [15:0]       sram_dq_i,
    output logic [15:0]       sram_dq_o,
    output logic              sram_dq_t,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    if (WAIT < 1 || WAIT > WAIT_MAX) begin : g_wait_range
        $error("wb_sram: WAIT out of range 1..15");
    end

    localparam logic [3:0] WAIT_LD = 4'(WAIT - 1);

    state_t             state, state_nxt;
    half_t              half, half_nxt;
    logic [3:0]         cnt;
    logic [ADDR_W-2:0]  adr_q;
    logic [3:0]         sel_q;
    logic               we_q;
    logic [31:0]        dat_q;

    logic accept;
    logic active;

    // Upper longword address bits alias onto the SRAM.
    logic unused_adr;
    assign unused_adr = ^wb_adr_i[29:ADDR_W-1];

    assign accept = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign active = (state == ST_SETUP) || (state == ST_STROBE) || (state == ST_HOLD);

    always_comb begin
        state_nxt = state;
        half_nxt  = half;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (|(wb_sel_i & SEL_HI)) begin
                        state_nxt = ST_SETUP;
                        half_nxt  = HALF_HI;
                    end else if (|(wb_sel_i & SEL_LO)) begin
                        state_nxt = ST_SETUP;
                        half_nxt  = HALF_LO;
                    end else begin
                        state_nxt = ST_ACK;
                    end
                end
            end
            ST_SETUP:  state_nxt = ST_STROBE;
            ST_STROBE: if (cnt == 4'd0) state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (half == HALF_HI && |(sel_q & SEL_LO)) begin
                    state_nxt = ST_SETUP;
                    half_nxt  = HALF_LO;
                end else begin
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        // Master abandoned the cycle: drop the SRAM access without acknowledging.
        if (active && !wb_cyc_i) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            half     <= HALF_HI;
            cnt      <= 4'd0;
            adr_q    <= '0;
            sel_q    <= 4'd0;
            we_q     <= 1'b0;
            dat_q    <= 32'd0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'd0;
        end else begin
            state    <= state_nxt;
            half     <= half_nxt;
            wb_ack_o <= (state == ST_ACK);
            if (state == ST_IDLE && accept) begin
                adr_q    <= wb_adr_i[ADDR_W-2:0];
                sel_q    <= wb_sel_i;
                we_q     <= wb_we_i;
                dat_q    <= wb_dat_i;
                wb_dat_o <= 32'd0;
            end
            if (state == ST_SETUP)
                cnt <= WAIT_LD;
            else if (state == ST_STROBE && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (state == ST_STROBE && cnt == 4'd0 && !we_q) begin
                if (half == HALF_HI) wb_dat_o[31:16] <= sram_dq_i;
                else                 wb_dat_o[15:0]  <= sram_dq_i;
            end
        end
    end

    // SRAM pins decode straight from registered state so they never glitch between phases.
    always_comb begin
        sram_a    = {adr_q, half};
        sram_dq_o = (half == HALF_HI) ? dat_q[31:16] : dat_q[15:0];
        sram_ce_n = ~active;
        sram_oe_n = ~((state == ST_STROBE) && !we_q);
        sram_we_n = ~((state == ST_STROBE) && we_q);
        sram_dq_t = ~(active && we_q);
        sram_ub_n = ~(active && ((half == HALF_HI) ? sel_q[3] : sel_q[1]));
        sram_lb_n = ~(active && ((half == HALF_HI) ? sel_q[2] : sel_q[0]));
    end

endmodule

// File: tb/tb_wb_sram.sv
// Scoreboarded bench for wb_sram: directed cases plus randomized traffic against
// a byte-array reference memory and a behavioural asynchronous SRAM.
module tb_wb_sram;

    localparam int ADDR_W = 10;
    localparam int WAIT   = 2;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int LWORDS = DEPTH / 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              wb_cyc_i, wb_stb_i, wb_we_i;
    logic [3:0]        wb_sel_i;
    logic [29:0]       wb_adr_i;
    logic [31:0]       wb_dat_i;
    logic [31:0]       wb_dat_o;
    logic              wb_ack_o;
    logic [ADDR_W-1:0] sram_a;
    logic [15:0]       sram_dq_i, sram_dq_o;
    logic              sram_dq_t, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    wb_sram #(.ADDR_W(ADDR_W), .WAIT(WAIT)) dut (
        .clk(clk), .reset(reset),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .sram_a(sram_a), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o), .sram_dq_t(sram_dq_t),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Behavioural SRAM: reads combinational, writes on clock while we_n is low.
    logic [15:0] sram_mem [DEPTH];
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_a] : 16'hF00F;
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && !sram_dq_t) begin
            if (!sram_ub_n) sram_mem[sram_a][15:8] <= sram_dq_o[15:8];
            if (!sram_lb_n) sram_mem[sram_a][7:0]  <= sram_dq_o[7:0];
        end
    end

    // Reference: byte-addressed memory, byte k of longword L at index 4*L+k.
    logic [7:0] ref_b [4*LWORDS];

    function automatic logic [15:0] init_hw(int i);
        return 16'(i * 32'h1357) ^ 16'hA5C3;
    endfunction

    function automatic int lw_index(logic [29:0] adr);
        return int'(adr) % LWORDS;
    endfunction

    task automatic ref_write(input logic [29:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        int b;
        logic [31:0] d;
        b = 4 * lw_index(adr);
        d = dat;
        for (int k = 0; k < 4; k++)
            if (sel[3-k]) ref_b[b+k] = d[31-8*k -: 8];
    endtask

    function automatic logic [31:0] ref_read(input logic [29:0] adr, input logic [3:0] sel);
        int b;
        logic [31:0] r;
        b = 4 * lw_index(adr);
        r = 32'd0;
        if (sel[3:2] != 2'b00) r[31:16] = {ref_b[b], ref_b[b+1]};
        if (sel[1:0] != 2'b00) r[15:0]  = {ref_b[b+2], ref_b[b+3]};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    typedef struct {
        int          start;
        int          lat;
        bit          rd;
        logic [31:0] data;
        int          n;
    } exp_t;
    exp_t exp_q[$];

    // Monitor: per-cycle protocol checks and scoreboard pop on every acknowledge.
    initial begin
        int oe_lo = 0, we_lo = 0, ce_lo = 0;
        logic prev_stb = 1'b0;
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (wb_stb_i && !prev_stb) begin
                oe_lo = 0; we_lo = 0; ce_lo = 0;
            end
            prev_stb = wb_stb_i;
            if (!sram_oe_n) oe_lo++;
            if (!sram_we_n) we_lo++;
            if (!sram_ce_n) ce_lo++;
            chk("oe_we_exclusive", {31'd0, sram_oe_n | sram_we_n}, 32'd1);
            if (!sram_oe_n || sram_ce_n) chk("dq_t_released", {31'd0, sram_dq_t}, 32'd1);
            if (!sram_we_n) chk("dq_t_driven", {31'd0, sram_dq_t}, 32'd0);
            if (wb_ack_o) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_ack: got ack with no transfer pending (cycle %0d)", cyc_n);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_latency", cyc_n - e.start, e.lat);
                    if (e.rd) chk("read_data", wb_dat_o, e.data);
                    chk("oe_low_cycles", oe_lo, e.rd ? e.n * WAIT : 0);
                    chk("we_low_cycles", we_lo, e.rd ? 0 : e.n * WAIT);
                    chk("ce_low_cycles", ce_lo, e.n * (WAIT + 2));
                end
            end
        end
    end

    task automatic start_xfer(input logic we, input logic [29:0] adr, input logic [3:0] sel,
                              input logic [31:0] dat);
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        wb_we_i = we; wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;
    endtask

    task automatic end_xfer();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic xfer(input logic we, input logic [29:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat);
        exp_t e;
        int k;
        start_xfer(we, adr, sel, dat);
        e.n     = int'(sel[3:2] != 2'b00) + int'(sel[1:0] != 2'b00);
        e.start = cyc_n + 1;
        e.lat   = 1 + e.n * (WAIT + 2);
        e.rd    = !we;
        e.data  = we ? 32'd0 : ref_read(adr, sel);
        exp_q.push_back(e);
        if (we) ref_write(adr, sel, dat);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!wb_ack_o && k < 200);
        if (!wb_ack_o) begin
            total++; bad++;
            $display("FAIL ack_timeout: no ack within %0d cycles, want ack", k);
            void'(exp_q.pop_front());
        end
        end_xfer();
    endtask

    task automatic wait_for(input logic lo_half, input logic want_we);
        int k = 0;
        while (k < 50 && !(sram_a[0] == lo_half && (want_we ? !sram_we_n : !sram_oe_n))) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (k >= 50) begin
            bad++;
            $display("FAIL strobe_timeout: strobe never reached, want half %0d", lo_half);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ctl"}, {25'd0, wb_ack_o, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n,
                            sram_lb_n, sram_dq_t}, 32'h3F);
        chk({tag, "_dat_o"}, wb_dat_o, 32'd0);
        chk({tag, "_sram_a"}, 32'(sram_a), 32'd0);
        chk({tag, "_dq_o"}, 32'(sram_dq_o), 32'd0);
    endtask

    initial begin
        int acks;
        for (int i = 0; i < DEPTH; i++) begin
            sram_mem[i]  = init_hw(i);
            ref_b[2*i]   = init_hw(i)[15:8];
            ref_b[2*i+1] = init_hw(i)[7:0];
        end
        reset = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_sel_i = 4'd0; wb_adr_i = 30'd0; wb_dat_i = 32'd0;
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        reset = 1'b0;

        // Full longword write, read-back, single-byte write, empty select.
        xfer(1'b1, 30'h10, 4'b1111, 32'hDEADBEEF);
        @(negedge clk);
        chk("mem_0x20", 32'(sram_mem[32'h20]), 32'h0000DEAD);
        chk("mem_0x21", 32'(sram_mem[32'h21]), 32'h0000BEEF);
        xfer(1'b0, 30'h10, 4'b1111, 32'd0);
        xfer(1'b1, 30'h10, 4'b0100, 32'h00AA0000);
        @(negedge clk);
        chk("mem_0x20_byte", 32'(sram_mem[32'h20]), 32'h0000DEAA);
        chk("mem_0x21_kept", 32'(sram_mem[32'h21]), 32'h0000BEEF);
        xfer(1'b1, 30'h10, 4'b0000, 32'h12345678);
        xfer(1'b0, 30'h10, 4'b0000, 32'd0);
        xfer(1'b0, 30'h10, 4'b0011, 32'd0);

        // Master drops cyc mid HI strobe of a write: the HI half lands, no ack.
        start_xfer(1'b1, 30'h33, 4'b1111, 32'hCAFEF00D);
        wait_for(1'b0, 1'b1);
        end_xfer();
        ref_write(30'h33, 4'b1100, 32'hCAFEF00D);
        @(negedge clk);
        chk("abort_ctl", {29'd0, sram_we_n, sram_ce_n, sram_dq_t}, 32'h7);
        acks = 0;
        repeat (12) begin
            @(negedge clk);
            if (wb_ack_o) acks++;
        end
        chk("abort_no_ack", acks, 0);
        xfer(1'b0, 30'h33, 4'b1111, 32'd0);

        // Reset during LO strobe of a read.
        start_xfer(1'b0, 30'h10, 4'b1111, 32'd0);
        wait_for(1'b1, 1'b0);
        reset = 1'b1;
        end_xfer();
        @(negedge clk);
        chk_reset_values("midreset");
        reset = 1'b0;
        acks = 0;
        repeat (12) begin
            @(negedge clk);
            if (wb_ack_o) acks++;
        end
        chk("midreset_no_ack", acks, 0);

        // Random traffic on a few aliased longwords so reads see earlier writes.
        for (int t = 0; t < 200; t++) begin
            logic [29:0] adr;
            adr = 30'($urandom) & ~30'(LWORDS - 1) | 30'($urandom_range(0, 15));
            xfer(1'($urandom), adr, 4'($urandom), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1);
    end

endmodule

// File: doc/wb_sram.md
WB_SRAM -- requirements
Module: wb_sram

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, meaning SRAM halfword address width.
REQ-002 SHALL have parameter WAIT, default 2, range 1-15, meaning strobe-low cycles per SRAM access.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  reset, synchronous and active-high.
REQ-005 wb_cyc_i  in  1  Wishbone cycle.
REQ-006 wb_stb_i  in  1  Wishbone strobe.
REQ-007 wb_we_i  in  1  write when 1.
REQ-008 wb_sel_i  in  4  byte lanes, big-endian: sel[3]=dat[31:24]=lowest byte address.
REQ-009 wb_adr_i  in  30  longword address.
REQ-010 wb_dat_i  in  32  write data.
REQ-011 wb_dat_o  out  32  read data, registered.
REQ-012 wb_ack_o  out  1  one-cycle registered acknowledge.
REQ-013 sram_a  out  ADDR_W  halfword address.
REQ-014 sram_dq_i  in  16  SRAM read data.
REQ-015 sram_dq_o  out  16  SRAM write data.
REQ-016 sram_dq_t  out  1  1 = tristate (FPGA drives nothing).
REQ-017 sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  active-low SRAM controls.

Function
REQ-018 SHALL map a longword to two halfwords: HI half (dat[31:16], sel[3:2]) at sram_a={wb_adr_i[ADDR_W-2:0],0}, LO half (dat[15:0], sel[1:0]) at {wb_adr_i[ADDR_W-2:0],1}; upper address bits ignored (aliasing).
REQ-019 SHALL drive sram_ub_n=~sel[3]/~sel[1] and sram_lb_n=~sel[2]/~sel[0] for HI/LO halves.
REQ-020 FSM states: IDLE, SETUP, STROBE, HOLD, ACK; register half selects HI or LO.
REQ-021 IDLE: on wb_cyc_i&wb_stb_i&~wb_ack_o SHALL latch adr/sel/we/dat, clear wb_dat_o to 0, go to SETUP(HI) if sel[3:2]!=0, else SETUP(LO) if sel[1:0]!=0, else ACK.
REQ-022 SETUP: 1 cycle; ce_n=0, address/ub/lb valid, oe_n=we_n=1; on write dq_t=0 with half data.
REQ-023 STROBE: exactly WAIT cycles; read: oe_n=0; write: we_n=0, data held.
REQ-024 Read data SHALL be sampled from sram_dq_i on the last STROBE cycle into wb_dat_o[31:16] (HI) or [15:0] (LO).
REQ-025 HOLD: 1 cycle; oe_n=we_n=1, ce_n=0, address and write data unchanged; then SETUP(LO) if HI done and sel[1:0]!=0, else ACK.
REQ-026 ACK: wb_ack_o=1 for exactly one cycle, ce_n=1, dq_t=1; next state IDLE; no back-to-back ack on same strobe.
REQ-027 Latency strobe-sample to ack-high: 1+n*(WAIT+2) cycles, n = halves with non-zero sel; sel=0 gives 1 cycle, no SRAM activity.
REQ-028 sram_dq_t SHALL be 1 in all read and IDLE/ACK cycles; oe_n and we_n SHALL never be low simultaneously.
REQ-029 wb_cyc_i falling in SETUP/STROBE/HOLD SHALL abort: next edge IDLE, all strobes inactive, dq_t=1, no ack.
REQ-030 Internal WAIT counter width 4 bits; reloaded on every SETUP.

Reset
REQ-031 reset SHALL take effect at the next edge in any state, mid-access included: state=IDLE, wb_ack_o=0, wb_dat_o=0, sram_ce_n=oe_n=we_n=ub_n=lb_n=1, sram_dq_t=1, sram_a=0, sram_dq_o=0.

Structure
REQ-032 Shared package wb_sram_pkg SHALL hold the state encoding and the WAIT upper limit; Wishbone sel-lane constants shared with the CPU bus interface also live there.
REQ-033 Single module; no sub-module is natural (counter and FSM are too small to split).

Verification (WAIT=2, SRAM behavioural model)
REQ-034 Write adr=0x10, sel=1111, dat=0xDEADBEEF -> sram 0x20=0xDEAD, 0x21=0xBEEF, ack 9 cycles after strobe sampled, one cycle wide.
REQ-035 Read adr=0x10, sel=1111 -> wb_dat_o=0xDEADBEEF with ack; oe_n low 2 cycles per half, dq_t=1 throughout.
REQ-036 Byte write sel=0100, dat=0x00AA0000 to adr=0x10 -> only lb_n low on HI half, sram 0x20=0xDEAA, no LO access, ack after 5 cycles.
REQ-037 sel=0000 -> ack 1 cycle later, ce_n never asserted.
REQ-038 Drop wb_cyc_i during HI STROBE of a write -> we_n high next edge, no ack, next transfer completes normally.
REQ-039 Assert reset during LO STROBE of a read -> all outputs at REQ-031 values next edge, no ack.
